// File: rtl/ex_stage_pipe_pkg.sv
// Shared ISA definitions for the execute stage: ALU command codes,
// shift types, NZCV flag indices and the multiplier FSM encoding.
package ex_stage_pipe_pkg;

  typedef enum logic [3:0] {
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001,
    CMD_MUL = 4'b1010
  } alu_cmd_t;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/ex_stage_pipe_mul.sv
// ex_mul_iter: shift-add multiplier, one bit per cycle, low DATA_W bits.
// Ports: start/abort/consume controls, a/b operands, busy/done, product.
module ex_mul_iter
  import ex_stage_pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              consume,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  mul_state_t        state, state_nx;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mcand, mplier, acc;

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start && !abort) state_nx = ST_MUL;
      ST_MUL: begin
        if (abort)
          state_nx = ST_IDLE;
        else if (count == CNT_W'(DATA_W - 1))
          state_nx = ST_DONE;
      end
      ST_DONE: if (abort || consume) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      state <= state_nx;
      if (abort) begin
        count <= '0;
      end else if (state == ST_IDLE && start) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        count  <= '0;
      end else if (state == ST_MUL) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end
    end
  end

  assign busy    = (state == ST_MUL);
  assign done    = (state == ST_DONE);
  assign product = acc;

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage: operand-2 shifter, ALU with NZCV, branch target,
// iterative MUL and the EX/MEM pipeline register (flush > stall > load).
module ex_stage_pipe
  import ex_stage_pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int IMM_W      = 24,
  parameter int SHIFT_W    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ADDR_W-1:0]     pc_in,
  input  logic [3:0]            status_reg_in,
  input  logic [DATA_W-1:0]     rn_in,
  input  logic [DATA_W-1:0]     rm_in,
  input  logic [IMM_W-1:0]      signed_immediate_in,
  input  logic [SHIFT_W-1:0]    shift_operand_in,
  input  logic                  is_immediate_in,
  input  logic [3:0]            execute_command_in,
  input  logic                  s_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  wb_enable_in,
  input  logic [REG_ADDR_W-1:0] dest_reg_in,
  input  logic                  stall_in,
  input  logic                  flush_in,
  output logic                  ready_out,
  output logic                  out_valid,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  wb_enable_out,
  output logic [REG_ADDR_W-1:0] dest_reg_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [DATA_W-1:0]     reg_file_out2_out,
  output logic [3:0]            status_bits,
  output logic                  status_we,
  output logic [ADDR_W-1:0]     branch_address
);

  localparam int MSB = DATA_W - 1;

  logic              is_mem, is_mul;
  logic              mul_busy, mul_done, mul_start;
  logic [DATA_W-1:0] mul_prod;
  logic [DATA_W-1:0] imm8, op2, b_eff, res;
  logic [31:0]       rot_amt, sh_amt;
  logic [DATA_W:0]   sum;
  logic              arith, known, c0;
  logic [3:0]        nzcv;
  logic [ADDR_W-1:0] imm_ext;

  assign is_mem = mem_read_in | mem_write_in;
  assign is_mul = (execute_command_in == CMD_MUL);

  // Shift amounts are taken modulo DATA_W (power of two assumed).
  assign imm8    = DATA_W'(shift_operand_in[7:0]);
  assign rot_amt = 32'({shift_operand_in[11:8], 1'b0}) % 32'(DATA_W);
  assign sh_amt  = 32'(shift_operand_in[11:7]) % 32'(DATA_W);

  always_comb begin
    op2 = '0;
    if (is_mem) begin
      op2 = DATA_W'(shift_operand_in);
    end else if (is_immediate_in) begin
      op2 = (imm8 >> rot_amt) | (imm8 << (32'(DATA_W) - rot_amt));
    end else begin
      unique case (shift_operand_in[6:5])
        SH_LSL: op2 = rm_in << sh_amt;
        SH_LSR: op2 = rm_in >> sh_amt;
        SH_ASR: op2 = $signed(rm_in) >>> sh_amt;
        SH_ROR: op2 = (rm_in >> sh_amt)
                    | (rm_in << (32'(DATA_W) - sh_amt));
        default: op2 = '0;
      endcase
    end
  end

  // Subtraction is rn + ~op2 + cin, so C reads as "no borrow".
  always_comb begin
    res   = '0;
    nzcv  = status_reg_in;
    arith = 1'b0;
    known = 1'b1;
    b_eff = op2;
    c0    = 1'b0;
    case (execute_command_in)
      CMD_MOV: res = op2;
      CMD_MVN: res = ~op2;
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin
        arith = 1'b1;
        c0    = status_reg_in[FLAG_C];
      end
      CMD_SUB: begin
        arith = 1'b1;
        b_eff = ~op2;
        c0    = 1'b1;
      end
      CMD_SBC: begin
        arith = 1'b1;
        b_eff = ~op2;
        c0    = status_reg_in[FLAG_C];
      end
      CMD_AND: res = rn_in & op2;
      CMD_ORR: res = rn_in | op2;
      CMD_EOR: res = rn_in ^ op2;
      CMD_MUL: res = mul_prod;
      default: known = 1'b0;
    endcase
    sum = {1'b0, rn_in} + {1'b0, b_eff}
        + {{DATA_W{1'b0}}, c0};
    if (arith) res = sum[MSB:0];
    if (known) begin
      nzcv[FLAG_N] = res[MSB];
      nzcv[FLAG_Z] = (res == '0);
    end
    if (arith) begin
      nzcv[FLAG_C] = sum[DATA_W];
      nzcv[FLAG_V] = (rn_in[MSB] == b_eff[MSB])
                   && (res[MSB] != rn_in[MSB]);
    end
  end

  assign status_bits = nzcv;

  assign imm_ext        = ADDR_W'($signed(signed_immediate_in));
  assign branch_address = pc_in + (imm_ext << 2);

  assign mul_start = in_valid & is_mul & ~mul_busy
                   & ~mul_done & ~flush_in;

  ex_mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (flush_in),
    .consume (~stall_in & ~flush_in),
    .a       (rn_in),
    .b       (rm_in),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign ready_out = ~(in_valid & is_mul & ~mul_done);
  assign status_we = in_valid & s_in & ready_out
                   & ~stall_in & ~flush_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid         <= 1'b0;
      mem_read_out      <= 1'b0;
      mem_write_out     <= 1'b0;
      wb_enable_out     <= 1'b0;
      dest_reg_out      <= '0;
      alu_result_out    <= '0;
      reg_file_out2_out <= '0;
    end else if (flush_in) begin
      out_valid     <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      wb_enable_out <= 1'b0;
    end else if (!stall_in) begin
      if (ready_out) begin
        out_valid         <= in_valid;
        mem_read_out      <= in_valid & mem_read_in;
        mem_write_out     <= in_valid & mem_write_in;
        wb_enable_out     <= in_valid & wb_enable_in;
        dest_reg_out      <= dest_reg_in;
        alu_result_out    <= res;
        reg_file_out2_out <= rm_in;
      end else begin
        out_valid     <= 1'b0;
        mem_read_out  <= 1'b0;
        mem_write_out <= 1'b0;
        wb_enable_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe: a 32-bit instance for ALU,
// branch, stall and flush; an 8-bit instance for the iterative MUL.
module tb_ex_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [3:0]  st = '0;
  logic [31:0] rn = '0, rm = '0;
  logic [23:0] simm = '0;
  logic [11:0] shop = '0;
  logic        isimm = 1'b0;
  logic [3:0]  cmd = '0;
  logic        s = 1'b0, mr = 1'b0, mw = 1'b0, wb = 1'b1;
  logic [3:0]  dest = '0;
  logic        stall = 1'b0, flush = 1'b0;

  logic        o32_ready, o32_ov, o32_mr, o32_mw, o32_wb, o32_we;
  logic [3:0]  o32_dst, o32_st;
  logic [31:0] o32_alu, o32_rf2, o32_br;

  logic        o8_ready, o8_ov, o8_mr, o8_mw, o8_wb, o8_we;
  logic [3:0]  o8_dst, o8_st;
  logic [7:0]  o8_alu, o8_rf2;
  logic [31:0] o8_br;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  dest;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_stage_pipe dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc),
    .status_reg_in(st), .rn_in(rn), .rm_in(rm),
    .signed_immediate_in(simm), .shift_operand_in(shop),
    .is_immediate_in(isimm), .execute_command_in(cmd), .s_in(s),
    .mem_read_in(mr), .mem_write_in(mw), .wb_enable_in(wb),
    .dest_reg_in(dest), .stall_in(stall), .flush_in(flush),
    .ready_out(o32_ready), .out_valid(o32_ov),
    .mem_read_out(o32_mr), .mem_write_out(o32_mw),
    .wb_enable_out(o32_wb), .dest_reg_out(o32_dst),
    .alu_result_out(o32_alu), .reg_file_out2_out(o32_rf2),
    .status_bits(o32_st), .status_we(o32_we),
    .branch_address(o32_br)
  );

  ex_stage_pipe #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pc_in(pc),
    .status_reg_in(st), .rn_in(rn[7:0]), .rm_in(rm[7:0]),
    .signed_immediate_in(simm), .shift_operand_in(shop),
    .is_immediate_in(isimm), .execute_command_in(cmd), .s_in(s),
    .mem_read_in(mr), .mem_write_in(mw), .wb_enable_in(wb),
    .dest_reg_in(dest), .stall_in(stall), .flush_in(flush),
    .ready_out(o8_ready), .out_valid(o8_ov),
    .mem_read_out(o8_mr), .mem_write_out(o8_mw),
    .wb_enable_out(o8_wb), .dest_reg_out(o8_dst),
    .alu_result_out(o8_alu), .reg_file_out2_out(o8_rf2),
    .status_bits(o8_st), .status_we(o8_we),
    .branch_address(o8_br)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [11:0] so,
                       input logic im, input logic [3:0] d,
                       input logic [31:0] exp, input bit push);
    in_valid = 1'b1;
    cmd = c; rn = a; rm = b; shop = so; isimm = im; dest = d;
    if (push) sb.push_back('{res: exp, dest: d});
  endtask

  task automatic exec(input string tag, input bit sel8);
    exp_t e;
    @(posedge clk); #1;
    check({tag, "_sbn"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_res"}, sel8 ? {24'h0, o8_alu} : o32_alu, e.res);
      check({tag, "_dst"}, sel8 ? {28'h0, o8_dst} : {28'h0, o32_dst},
            {28'h0, e.dest});
      check({tag, "_vld"}, sel8 ? 32'(o8_ov) : 32'(o32_ov), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic count_stall(output int n);
    n = 0;
    #1;
    while (o8_ready === 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int n;
    logic [31:0] a, b, x;

    repeat (2) @(negedge clk);
    check("rst_vld", 32'(o32_ov), 0);
    check("rst_wb", 32'(o32_wb), 0);
    check("rst_alu", o32_alu, 0);
    check("rst_dst", {28'h0, o32_dst}, 0);
    check("rst_rf2", o32_rf2, 0);
    rst = 1'b1;
    @(negedge clk);

    s = 1'b1;
    drive(4'b0010, 32'h7FFF_FFFF, 0, 12'h001, 1'b1, 4'd3,
          32'h8000_0000, 1);
    #1;
    check("add_nzcv", {28'h0, o32_st}, 32'b1001);
    check("add_we", 32'(o32_we), 1);
    check("add_rdy", 32'(o32_ready), 1);
    exec("add_ovf", 0);

    drive(4'b0100, 5, 5, 12'h000, 1'b0, 4'd4, 0, 1);
    #1;
    check("sub_nzcv", {28'h0, o32_st}, 32'b0110);
    exec("sub_zero", 0);

    pc = 32'h100; simm = 24'hFF_FFFF;
    #1;
    check("branch", o32_br, 32'h0000_00FC);

    drive(4'b0001, 0, 0, 12'h1FF, 1'b1, 4'd5, 32'hC000_003F, 1);
    exec("imm_ror", 0);
    drive(4'b0001, 0, 32'h8000_0000, 12'h240, 1'b0, 4'd6,
          32'hF800_0000, 1);
    exec("asr4", 0);
    drive(4'b0001, 0, 32'h1, 12'h0E0, 1'b0, 4'd7, 32'h8000_0000, 1);
    exec("ror1", 0);
    drive(4'b0001, 0, 32'h8000_0000, 12'hFA0, 1'b0, 4'd8, 32'h1, 1);
    exec("lsr31", 0);

    mr = 1'b1;
    drive(4'b0010, 32'h1000, 0, 12'hFFF, 1'b1, 4'd9, 32'h1FFF, 1);
    @(posedge clk); #1;
    check("mem_rd", 32'(o32_mr), 1);
    check("mem_res", o32_alu, sb[0].res);
    void'(sb.pop_front());
    @(negedge clk);
    in_valid = 1'b0; mr = 1'b0;

    st = 4'b0010;
    drive(4'b0011, 1, 2, 12'h000, 1'b0, 4'd1, 4, 1);
    #1;
    check("adc_nzcv", {28'h0, o32_st}, 0);
    exec("adc", 0);

    st = 4'b1010;
    drive(4'b1111, 7, 9, 12'h000, 1'b0, 4'd2, 0, 1);
    #1;
    check("bad_nzcv", {28'h0, o32_st}, 32'b1010);
    exec("bad_cmd", 0);

    st = 4'b0011;
    drive(4'b1001, 0, 0, 12'h000, 1'b0, 4'd3, 32'hFFFF_FFFF, 1);
    #1;
    check("mvn_nzcv", {28'h0, o32_st}, 32'b1011);
    exec("mvn", 0);
    st = 4'b0000;

    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      x = i[0] ? (a ^ b) : (a + b);
      drive(i[0] ? 4'b1000 : 4'b0010, a, b, 12'h000, 1'b0,
            4'(i), x, 1);
      exec($sformatf("rnd%0d", i), 0);
    end

    drive(4'b0010, 10, 20, 12'h000, 1'b0, 4'd10, 30, 1);
    exec("pre_stall", 0);
    stall = 1'b1;
    drive(4'b0010, 1, 1, 12'h000, 1'b0, 4'd11, 2, 1);
    #1;
    check("stall_we", 32'(o32_we), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall_alu%0d", i), o32_alu, 30);
      check($sformatf("stall_vld%0d", i), 32'(o32_ov), 1);
      check($sformatf("stall_dst%0d", i), {28'h0, o32_dst}, 10);
    end
    @(negedge clk);
    stall = 1'b0;
    exec("post_stall", 0);

    flush = 1'b1;
    drive(4'b0010, 3, 3, 12'h000, 1'b0, 4'd12, 6, 0);
    @(posedge clk); #1;
    check("flush_vld", 32'(o32_ov), 0);
    check("flush_wb", 32'(o32_wb), 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; s = 1'b0;
    @(negedge clk);

    drive(4'b1010, 13, 11, 12'h000, 1'b0, 4'd5, 32'h8F, 1);
    count_stall(n);
    check("mul_stall", n, 9);
    check("mul_bubble", 32'(o8_ov), 0);
    check("mul_nz", {30'h0, o8_st[3:2]}, 32'b10);
    exec("mul13x11", 1);

    drive(4'b1010, 7, 3, 12'h000, 1'b0, 4'd6, 32'h15, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    check("mflush_vld", 32'(o8_ov), 0);
    @(negedge clk);
    flush = 1'b0;
    count_stall(n);
    check("mflush_restart", n, 9);
    exec("mul7x3", 1);

    drive(4'b1010, 2, 2, 12'h000, 1'b0, 4'd9, 4, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mrst_alu", {24'h0, o8_alu}, 0);
    check("mrst_dst", {28'h0, o8_dst}, 0);
    check("mrst_rf2", {24'h0, o8_rf2}, 0);
    check("mrst_vld", 32'(o8_ov), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    drive(4'b0010, 3, 4, 12'h000, 1'b0, 4'd7, 7, 1);
    #1;
    check("post_rst_rdy", 32'(o8_ready), 1);
    exec("post_rst_add", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
